mem_port_arb: RTL

Two-requester arbiter that shares one single-port synchronous memory between the instruction-fetch port and the data (MEM-stage) port of the RV32I pipeline. It grants at most one access per cycle and returns read data one cycle later, tagged to the granted requester. It also bounds fetch starvation under back-to-back data traffic. It sits between the IF/MEM stages and a unified memory array.

---
 rtl/mem_port_arb.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arb.sv
// -----------------------------------------------------------------------------
// mem_port_arb
//
// Shares one single-port synchronous memory between the instruction-fetch
// port (I) and the data / MEM-stage port (D) of the RV32I pipeline.
// Grants at most one access per cycle (combinational grant), and returns
// read data one cycle after the grant, tagged to the port that issued it.
//
// Default conflict policy: data wins, unless fetch has been denied for
// STARVE_MAX or more consecutive cycles, in which case fetch wins.
// Optional build macro MEM_PORT_ARB_RR_EN: conflicts are resolved strictly
// round-robin instead, and the starvation counter is not built.
//
// Parameters:
//   ADDR_W      memory word-address width (m_addr_o = byte addr [ADDR_W+1:2])
//   STARVE_MAX  denied-fetch cycles before fetch wins a conflict (1..15)
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   i_req_i, i_addr_i              fetch read request / byte address
//   i_gnt_o                        fetch accepted this cycle (combinational)
//   i_rvalid_o, i_rdata_o          fetch read data return (valid registered)
//   d_req_i, d_we_i, d_be_i        data request, write enable, byte enables
//   d_addr_i, d_wdata_i            data byte address and write data
//   d_gnt_o                        data accepted this cycle (combinational)
//   d_rvalid_o, d_rdata_o          data read return (reads only)
//   m_en_o, m_we_o, m_be_o         memory enable, write strobe, byte enables
//   m_addr_o, m_wdata_o            memory word address and write data
//   m_rdata_i                      memory read data, valid cycle after m_en_o
// -----------------------------------------------------------------------------
module mem_port_arb #(
    parameter int ADDR_W     = 15,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              i_req_i,
    input  logic [31:0]       i_addr_i,
    output logic              i_gnt_o,
    output logic              i_rvalid_o,
    output logic [31:0]       i_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [3:0]        d_be_i,
    input  logic [31:0]       d_addr_i,
    input  logic [31:0]       d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [31:0]       d_rdata_o,
    output logic              m_en_o,
    output logic              m_we_o,
    output logic [3:0]        m_be_o,
    output logic [ADDR_W-1:0] m_addr_o,
    output logic [31:0]       m_wdata_o,
    input  logic [31:0]       m_rdata_i
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    owner_e owner_q, owner_d;
    logic   i_gnt_s, d_gnt_s;
    logic   fetch_wins_s;

    // Byte-offset bits and bits above the memory range are not used.
    logic unused_s;
    assign unused_s = ^{i_addr_i[1:0], i_addr_i[31:ADDR_W+2],
                        d_addr_i[1:0], d_addr_i[31:ADDR_W+2]};

`ifdef MEM_PORT_ARB_RR_EN
    // last_q = 1'b1 : fetch won the most recent conflict; 1'b0 : data did.
    logic last_q, last_d;

    assign fetch_wins_s = ~last_q;

    // Round-robin history: only updated on cycles where both ports compete.
    always_comb begin
        last_d = last_q;
        if (rst_ni && i_req_i && d_req_i) begin
            last_d = i_gnt_s;
        end else begin
            last_d = last_q;
        end
    end

    // Round-robin history register; resets as if data won last.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end
`else
    localparam logic [3:0] STARVE_MAX_C = 4'(STARVE_MAX);

    logic [3:0] starve_q, starve_d;

    assign fetch_wins_s = (starve_q >= STARVE_MAX_C);

    // Starvation counter: counts consecutive denied fetch cycles, saturating.
    always_comb begin
        starve_d = 4'd0;
        if (i_req_i && !i_gnt_s) begin
            starve_d = (starve_q == 4'd15) ? 4'd15 : (starve_q + 4'd1);
        end else begin
            starve_d = 4'd0;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
        end
    end
`endif

    // Grant selection; both grants are held low while reset is asserted.
    always_comb begin
        i_gnt_s = 1'b0;
        d_gnt_s = 1'b0;
        if (!rst_ni) begin
            i_gnt_s = 1'b0;
            d_gnt_s = 1'b0;
        end else if (i_req_i && d_req_i) begin
            if (fetch_wins_s) begin
                i_gnt_s = 1'b1;
            end else begin
                d_gnt_s = 1'b1;
            end
        end else begin
            i_gnt_s = i_req_i;
            d_gnt_s = d_req_i;
        end
    end

    assign i_gnt_o = i_gnt_s;
    assign d_gnt_o = d_gnt_s;

    // Memory request mux from the granted port; all-zero when idle.
    always_comb begin
        m_en_o    = 1'b0;
        m_we_o    = 1'b0;
        m_be_o    = 4'b0000;
        m_addr_o  = {ADDR_W{1'b0}};
        m_wdata_o = 32'd0;
        if (i_gnt_s) begin
            m_en_o   = 1'b1;
            m_be_o   = 4'b1111;
            m_addr_o = i_addr_i[ADDR_W+1:2];
        end else if (d_gnt_s) begin
            m_en_o    = 1'b1;
            m_we_o    = d_we_i;
            m_be_o    = d_we_i ? d_be_i : 4'b1111;
            m_addr_o  = d_addr_i[ADDR_W+1:2];
            m_wdata_o = d_we_i ? d_wdata_i : 32'd0;
        end else begin
            m_en_o = 1'b0;
        end
    end

    // Owner of the read data returning next cycle; writes return nothing.
    always_comb begin
        owner_d = OWN_NONE;
        if (i_gnt_s) begin
            owner_d = OWN_I;
        end else if (d_gnt_s && !d_we_i) begin
            owner_d = OWN_D;
        end else begin
            owner_d = OWN_NONE;
        end
    end

    // Return-owner register; a reset drops any outstanding read.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    assign i_rvalid_o = (owner_q == OWN_I);
    assign d_rvalid_o = (owner_q == OWN_D);
    assign i_rdata_o  = m_rdata_i;
    assign d_rdata_o  = m_rdata_i;

endmodule
